// File: rtl/gcd_host.sv
// -----------------------------------------------------------------------------
// gcd_host
//
// Self-test initiator for the gcd core's ld/rdy job protocol. It generates
// pseudo-random operand pairs from a 32-bit Galois LFSR, launches them one at
// a time with a single-cycle ld pulse, and collects each result on rdy. It
// keeps job counters and a running checksum of results, aborts a job that
// takes too long, and flags a result pulse that arrives while a job is still
// being launched.
//
// Parameters
//   WIDTH    operand/result width, 2..16
//   NJOBS    jobs per run, 1..65535
//   TIMEOUT  maximum WAIT cycles per job before the run aborts, >= 1
//   SEED     LFSR seed; 0 is replaced by 1 (the all-zero state is a lock-up)
//
// Ports
//   clk       in   1      clock, all state on the rising edge
//   reset     in   1      synchronous, active-low reset
//   start     in   1      level; begins a run when sampled in IDLE/DONE/TOUT
//   a         out  WIDTH  operand A, registered, valid with ld, held after
//   b         out  WIDTH  operand B, registered, valid with ld, held after
//   ld        out  1      one-cycle job launch pulse to the core
//   q         in   WIDTH  result from the core, valid with rdy
//   rdy       in   1      one-cycle result-valid pulse from the core
//   busy      out  1      a run is in progress (ISSUE or WAIT)
//   done      out  1      run completed all NJOBS jobs
//   timeout   out  1      run aborted on a job that exceeded TIMEOUT
//   err       out  1      sticky: rdy seen while a job was being launched
//   nld       out  16     jobs issued this run
//   nrdy      out  16     results accepted this run
//   checksum  out  16     sum of accepted results, zero-extended, mod 2^16
// -----------------------------------------------------------------------------
module gcd_host #(
    parameter int          WIDTH   = 8,
    parameter int          NJOBS   = 100,
    parameter int          TIMEOUT = 1023,
    parameter logic [31:0] SEED    = 32'hACE1_5EED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             ld,
    input  logic [WIDTH-1:0] q,
    input  logic             rdy,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             err,
    output logic [15:0]      nld,
    output logic [15:0]      nrdy,
    output logic [15:0]      checksum
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_TOUT  = 3'd4;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;

    // The wait counter must be able to hold TIMEOUT itself (its value on the
    // cycle the state machine leaves for TOUT).
    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]      NJOBS_16  = 16'(NJOBS);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [31:0]      lfsr;
    logic [CNT_W-1:0] wait_cnt;

    // -------------------------------------------------------------------------
    // Operand generation
    // -------------------------------------------------------------------------
    logic [31:0]      lfsr_next;
    logic [WIDTH-1:0] raw_a;
    logic [WIDTH-1:0] raw_b;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;

    // Galois form, shifting right: the bit falling out of position 0 is fed
    // back into every tap of the mask.
    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);

    assign raw_a = lfsr[WIDTH-1:0];
    assign raw_b = lfsr[16+WIDTH-1:16];

    // The core must never see a zero operand.
    assign opnd_a = (raw_a == '0) ? WIDTH'(1) : raw_a;
    assign opnd_b = (raw_b == '0) ? WIDTH'(1) : raw_b;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    logic        launch;
    logic        restart;
    logic [15:0] nrdy_inc;
    logic        last_job;

    assign nrdy_inc = nrdy + 16'd1;
    assign last_job = (nrdy_inc == NJOBS_16);

    // A run restarted from DONE/TOUT starts with clean counters; from IDLE
    // they are already zero because IDLE is only reachable through reset.
    assign restart = start && ((state == S_DONE) || (state == S_TOUT));

    // ISSUE never lasts more than one cycle, so entering it is a launch.
    assign launch = (state_next == S_ISSUE);

    // NOTE: every signal assigned in an always_comb block receives a default
    // on entry, so no path through the case can leave it unassigned and infer
    // a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A result on the last permitted WAIT cycle still wins over
                // the timeout.
                if (rdy) begin
                    state_next = last_job ? S_DONE : S_ISSUE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_TOUT;
                end
            end
            S_DONE, S_TOUT: begin
                if (start) state_next = S_ISSUE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register, regardless
    // of the order of statements in the block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            lfsr     <= SEED_EFF;
            wait_cnt <= '0;
            a        <= '0;
            b        <= '0;
            err      <= 1'b0;
            nld      <= 16'd0;
            nrdy     <= 16'd0;
            checksum <= 16'd0;
        end else begin
            state <= state_next;

            // Operands are captured on the edge into ISSUE so they are stable
            // for the whole ld cycle and held until the next launch.
            if (launch) begin
                a <= opnd_a;
                b <= opnd_b;
            end

            if (restart) begin
                err      <= 1'b0;
                nld      <= 16'd0;
                nrdy     <= 16'd0;
                checksum <= 16'd0;
            end

            case (state)
                S_ISSUE: begin
                    lfsr     <= lfsr_next;
                    nld      <= nld + 16'd1;
                    wait_cnt <= '0;
                    // A result during launch cannot belong to this job and
                    // the previous one has already been retired; flag it and
                    // drop q.
                    if (rdy) err <= 1'b1;
                end
                S_WAIT: begin
                    if (rdy) begin
                        nrdy     <= nrdy_inc;
                        checksum <= checksum + 16'(q);
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from the registered state
    // -------------------------------------------------------------------------
    assign ld      = (state == S_ISSUE);
    assign busy    = (state == S_ISSUE) || (state == S_WAIT);
    assign done    = (state == S_DONE);
    assign timeout = (state == S_TOUT);

endmodule

// File: tb/tb_gcd_host.sv
// -----------------------------------------------------------------------------
// tb_gcd_host
//
// Bench for gcd_host. dut drives a behavioural responder with a configurable
// ld-to-rdy latency; dut2 uses a seed whose low operand byte is zero and is
// used only for the zero-substitution check. Operands are compared on every
// ld against an independent model of the LFSR stream.
// -----------------------------------------------------------------------------
module tb_gcd_host;

    localparam int          W     = 8;
    localparam int          NJ    = 4;
    localparam int          TO    = 15;
    localparam logic [31:0] SEED1 = 32'hACE1_5EED;
    localparam logic [31:0] SEED2 = 32'h0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, start2;
    logic [W-1:0] a, b, q;
    logic         ld, rdy, busy, done, timeout, err;
    logic [15:0]  nld, nrdy, checksum;

    logic [W-1:0] a2, b2, q2;
    logic         ld2, rdy2, busy2, done2, tout2, err2;
    logic [15:0]  nld2, nrdy2, cks2;

    gcd_host #(.WIDTH(W), .NJOBS(NJ), .TIMEOUT(TO), .SEED(SEED1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a(a), .b(b), .ld(ld), .q(q), .rdy(rdy),
        .busy(busy), .done(done), .timeout(timeout), .err(err),
        .nld(nld), .nrdy(nrdy), .checksum(checksum)
    );

    gcd_host #(.WIDTH(W), .NJOBS(1), .TIMEOUT(TO), .SEED(SEED2)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .a(a2), .b(b2), .ld(ld2), .q(q2), .rdy(rdy2),
        .busy(busy2), .done(done2), .timeout(tout2), .err(err2),
        .nld(nld2), .nrdy(nrdy2), .checksum(cks2)
    );

    // -------------------------------------------------------------------------
    // Scoring
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference helpers
    // -------------------------------------------------------------------------
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [W-1:0] nz(input logic [W-1:0] v);
        return (v == '0) ? W'(1) : v;
    endfunction

    function automatic logic [W-1:0] gcd8(input logic [W-1:0] x_in, input logic [W-1:0] y_in);
        logic [W-1:0] x, y, t;
        x = x_in;
        y = y_in;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // -------------------------------------------------------------------------
    // Cycle counter, rdy pulse counter
    // -------------------------------------------------------------------------
    int cyc = 0;
    int rdy_cnt = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rdy) rdy_cnt++;
    end

    // -------------------------------------------------------------------------
    // Responder: returns rdy resp_lat cycles after ld (resp_lat >= 1)
    // -------------------------------------------------------------------------
    int           resp_lat    = 3;
    bit           resp_silent = 1'b0;
    bit           resp_gcd    = 1'b0;
    bit           resp_spur   = 1'b0;
    logic [W-1:0] resp_q      = 8'd5;

    initial begin
        int           cnt;
        logic [W-1:0] pend;
        cnt  = 0;
        pend = '0;
        rdy  = 1'b0;
        q    = '0;
        forever begin
            @(negedge clk);
            rdy = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rdy = 1'b1;
                    q   = pend;
                end
            end
            if (ld && !resp_silent) begin
                pend = resp_gcd ? gcd8(a, b) : resp_q;
                if (resp_spur) begin
                    // Protocol violation: result pulse in the ld cycle itself.
                    rdy       = 1'b1;
                    q         = 8'hAA;
                    resp_spur = 1'b0;
                end
                cnt = resp_lat;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor: operand check on every ld, ld and timeout-rise timestamps
    // -------------------------------------------------------------------------
    logic [31:0] model_lfsr = SEED1;
    int          model_sum  = 0;
    int          ld_q[$];
    int          tout_q[$];

    initial begin
        logic         prev_to;
        logic [W-1:0] ea, eb;
        prev_to = 1'b0;
        forever begin
            @(negedge clk);
            if (ld) begin
                ea = nz(model_lfsr[W-1:0]);
                eb = nz(model_lfsr[16+W-1:16]);
                check("ld_a", 32'(a), 32'(ea));
                check("ld_b", 32'(b), 32'(eb));
                model_sum  += int'(gcd8(ea, eb));
                model_lfsr  = lfsr_step(model_lfsr);
                ld_q.push_back(cyc);
            end
            if (timeout && !prev_to) tout_q.push_back(cyc);
            prev_to = timeout;
        end
    end

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct {
        string        name;
        int           lat;
        bit           silent;
        bit           use_gcd;
        logic [W-1:0] qval;
        bit           exp_done;
        bit           exp_tout;
        int           exp_nld;
        int           exp_nrdy;
        int           exp_cks;   // -1: take the model gcd sum
    } vec_t;

    vec_t vecs[7];

    task automatic check_idle(input string tag);
        check({tag, "_a"},        32'(a), 0);
        check({tag, "_b"},        32'(b), 0);
        check({tag, "_ld"},       32'(ld), 0);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_done"},     32'(done), 0);
        check({tag, "_timeout"},  32'(timeout), 0);
        check({tag, "_err"},      32'(err), 0);
        check({tag, "_nld"},      32'(nld), 0);
        check({tag, "_nrdy"},     32'(nrdy), 0);
        check({tag, "_checksum"}, 32'(checksum), 0);
    endtask

    task automatic pulse_start(output int s_cyc);
        ld_q.delete();
        tout_q.delete();
        model_sum = 0;
        start     = 1'b1;
        s_cyc     = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done || timeout) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, 32'(done || timeout), 1);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int s_cyc;
        int r0;
        int n;

        vecs[0] = '{"v_l3_q5",    3, 1'b0, 1'b0, 8'd5,   1'b1, 1'b0, 4, 4, 20};
        vecs[1] = '{"v_l1_q7",    1, 1'b0, 1'b0, 8'd7,   1'b1, 1'b0, 4, 4, 28};
        vecs[2] = '{"v_l15_edge", 15, 1'b0, 1'b0, 8'd3,  1'b1, 1'b0, 4, 4, 12};
        vecs[3] = '{"v_l16_tout", 16, 1'b0, 1'b0, 8'd9,  1'b0, 1'b1, 1, 0, 0};
        vecs[4] = '{"v_gcd",      3, 1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 4, 4, -1};
        vecs[5] = '{"v_q255",     2, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 4, 4, 1020};
        vecs[6] = '{"v_silent",   3, 1'b1, 1'b0, 8'd5,   1'b0, 1'b1, 1, 0, 0};

        reset  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        rdy2   = 1'b0;
        q2     = '0;

        // Reset held for three rising edges.
        repeat (3) @(negedge clk);
        check_idle("rst");
        check("rst2_flags", 32'({ld2, busy2, done2, tout2, err2}), 0);
        check("rst2_ops",   32'({a2, b2}), 0);
        check("rst2_cnt",   {nld2, nrdy2}, 0);
        check("rst2_cks",   32'(cks2), 0);
        reset = 1'b1;
        @(negedge clk);

        // Zero operand substitution: seed 0x0001_0000 gives raw a=0, raw b=1.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("zsub_ld",   32'(ld2), 1);
        check("zsub_a",    32'(a2), 1);
        check("zsub_b",    32'(b2), 1);
        check("zsub_busy", 32'(busy2), 1);

        // Table-driven runs; each starts from the previous run's end state.
        for (int i = 0; i < 7; i++) begin
            resp_lat    = vecs[i].lat;
            resp_silent = vecs[i].silent;
            resp_gcd    = vecs[i].use_gcd;
            resp_q      = vecs[i].qval;
            pulse_start(s_cyc);
            wait_end(vecs[i].name);
            check({vecs[i].name, "_done"},    32'(done), 32'(vecs[i].exp_done));
            check({vecs[i].name, "_timeout"}, 32'(timeout), 32'(vecs[i].exp_tout));
            check({vecs[i].name, "_busy"},    32'(busy), 0);
            check({vecs[i].name, "_err"},     32'(err), 0);
            check({vecs[i].name, "_nld"},     32'(nld), vecs[i].exp_nld);
            check({vecs[i].name, "_nrdy"},    32'(nrdy), vecs[i].exp_nrdy);
            check({vecs[i].name, "_checksum"}, 32'(checksum),
                  (vecs[i].exp_cks < 0) ? 32'(model_sum & 16'hFFFF) : vecs[i].exp_cks);
            check({vecs[i].name, "_ld_count"}, ld_q.size(), vecs[i].exp_nld);
            check({vecs[i].name, "_start_lat"},
                  (ld_q.size() > 0) ? ld_q[0] - s_cyc : -1, 1);
            if (vecs[i].exp_done) begin
                for (int k = 1; k < ld_q.size(); k++)
                    check({vecs[i].name, "_period"}, ld_q[k] - ld_q[k-1], vecs[i].lat + 1);
            end else begin
                check({vecs[i].name, "_tout_rise"},
                      (tout_q.size() > 0 && ld_q.size() > 0) ? tout_q[0] - ld_q[0] : -1, TO + 1);
            end
            repeat (25) @(negedge clk);
        end

        // Restart from TOUT: counters clear and ld fires on the next cycle.
        resp_silent = 1'b0;
        resp_gcd    = 1'b0;
        resp_lat    = 3;
        resp_q      = 8'd5;
        pulse_start(s_cyc);
        check("rs_ld",       32'(ld), 1);
        check("rs_nld",      32'(nld), 0);
        check("rs_nrdy",     32'(nrdy), 0);
        check("rs_checksum", 32'(checksum), 0);
        check("rs_timeout",  32'(timeout), 0);
        wait_end("rs");
        check("rs_end_nld",  32'(nld), 4);

        // Spurious rdy in the ld cycle: err set, q dropped, run completes.
        resp_spur = 1'b1;
        pulse_start(s_cyc);
        wait_end("spur");
        check("spur_err",      32'(err), 1);
        check("spur_done",     32'(done), 1);
        check("spur_nrdy",     32'(nrdy), 4);
        check("spur_checksum", 32'(checksum), 20);

        // err is cleared by the next start.
        pulse_start(s_cyc);
        check("errclr_ld",  32'(ld), 1);
        check("errclr_err", 32'(err), 0);
        wait_end("errclr");
        check("errclr_end_err", 32'(err), 0);

        // Reset during WAIT of job 2; the outstanding rdy lands in IDLE.
        resp_lat = 5;
        pulse_start(s_cyc);
        n = 0;
        while (ld_q.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_second_ld", ld_q.size(), 2);
        @(negedge clk);
        reset      = 1'b0;
        model_lfsr = SEED1;
        r0         = rdy_cnt;
        @(negedge clk);
        reset = 1'b1;
        check_idle("mid_rst");
        repeat (8) @(negedge clk);
        check("late_rdy_seen", rdy_cnt - r0, 1);
        check_idle("late_rdy");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d",
                 n_checks, n_errors);
        $fatal(1);
    end

endmodule
